// File: rtl/fp_subtractor_seq.sv
// Sequential floating-point subtractor, result = a - b (optional macro FPSUB_RNE_EN: round-to-nearest-even, else truncate).
// Latency: 3 cycles from accept to out_valid plus one cycle per normalization shift (NaN path is shorter).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_subtractor_seq #(
    parameter int X        = 32,
    parameter int EXP_BITS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [X-1:0] a,
    input  logic [X-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [X-1:0] result,
    output logic [2:0]   flags
);

    localparam int F       = X - EXP_BITS - 1;
    localparam int MW      = F + 4;              // {hidden, fraction, G, R, St}
    localparam int EW      = EXP_BITS + 2;       // signed, room for carry and underflow
    localparam int EXP_MAX = (1 << EXP_BITS) - 1;
    localparam logic [EXP_BITS-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]       EXP_ONE  = EW'(1);
    localparam logic [X-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(F-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;
    state_t state;

    // b_r holds -b: the sign is flipped on capture so the datapath is a signed add
    logic [X-1:0]          a_r, b_r;
    logic                  sign_l, eff_sub;
    logic signed [EW-1:0]  exp_r;
    logic [MW-1:0]         l_mant, s_mant;
    logic [MW:0]           mant_r;

    logic [EXP_BITS-1:0]   ea, eb, exp_diff;
    logic [MW-1:0]         ma, mb, l_raw, s_raw, s_shr, s_aligned;
    logic                  a_big, s_lost, special;

    always_comb begin
        ea        = a_r[X-2:F];
        eb        = b_r[X-2:F];
        ma        = (ea == '0) ? '0 : {1'b1, a_r[F-1:0], 3'b000};
        mb        = (eb == '0) ? '0 : {1'b1, b_r[F-1:0], 3'b000};
        a_big     = {ea, a_r[F-1:0]} >= {eb, b_r[F-1:0]};
        l_raw     = a_big ? ma : mb;
        s_raw     = a_big ? mb : ma;
        exp_diff  = a_big ? (ea - eb) : (eb - ea);
        s_shr     = s_raw >> exp_diff;
        // any bit pushed past St folds into the sticky position
        s_lost    = (s_shr << exp_diff) != s_raw;
        s_aligned = {s_shr[MW-1:1], s_shr[0] | s_lost};
        special   = (ea == EXP_ONES) || (eb == EXP_ONES);
    end

    logic [MW:0]          sum, cand_m;
    logic signed [EW-1:0] cand_e;
    logic                 cand_zero, cand_ready;

    // cand_m/cand_e: the mantissa this cycle produces (SUB result or one NORM step)
    always_comb begin
        sum    = eff_sub ? ({1'b0, l_mant} - {1'b0, s_mant})
                         : ({1'b0, l_mant} + {1'b0, s_mant});
        cand_m = sum;
        cand_e = exp_r;
        if (state == NORM) begin
            if (mant_r[MW]) begin
                cand_m = {1'b0, mant_r[MW:2], mant_r[1] | mant_r[0]};
                cand_e = exp_r + EXP_ONE;
            end else begin
                cand_m = {mant_r[MW-1:0], 1'b0};
                cand_e = exp_r - EXP_ONE;
            end
        end
        cand_zero  = (cand_m == '0);
        cand_ready = !cand_m[MW] && cand_m[MW-1];
    end

    logic [F-1:0] frac;
    logic [X-1:0] fin_result;
    logic [2:0]   fin_flags;
    logic         fin_carry;
`ifdef FPSUB_RNE_EN
    logic         round_up;
    logic [F:0]   frac_rnd;
`endif

    always_comb begin
        frac      = cand_m[MW-2:3];
        fin_carry = 1'b0;
`ifdef FPSUB_RNE_EN
        round_up  = cand_m[2] && (cand_m[3] || cand_m[1] || cand_m[0]);
        frac_rnd  = {1'b0, cand_m[MW-2:3]} + {{F{1'b0}}, round_up};
        frac      = frac_rnd[F-1:0];
`endif
        fin_result = '0;
        fin_flags  = '0;
        if (int'(cand_e) >= EXP_MAX) begin
            fin_result = {sign_l, EXP_ONES, {F{1'b0}}};
            fin_flags  = 3'b010;
        end else if (int'(cand_e) <= 0) begin
            fin_flags  = 3'b001;
        end else begin
`ifdef FPSUB_RNE_EN
            fin_carry  = frac_rnd[F];
`endif
            fin_result = {sign_l, cand_e[EXP_BITS-1:0], frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sign_l    <= 1'b0;
            eff_sub   <= 1'b0;
            exp_r     <= '0;
            l_mant    <= '0;
            s_mant    <= '0;
            mant_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= {~b[X-1], b[X-2:0]};
                        in_ready <= 1'b0;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (special) begin
                        result    <= QNAN;
                        flags     <= 3'b100;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sign_l  <= a_big ? a_r[X-1] : b_r[X-1];
                        eff_sub <= a_r[X-1] ^ b_r[X-1];
                        exp_r   <= a_big ? {2'b00, ea} : {2'b00, eb};
                        l_mant  <= l_raw;
                        s_mant  <= s_aligned;
                        state   <= SUB;
                    end
                end
                SUB, NORM: begin
                    mant_r <= cand_m;
                    exp_r  <= cand_e;
                    if (cand_zero) begin
                        result    <= '0;
                        flags     <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (cand_ready && !fin_carry) begin
                        result    <= fin_result;
                        flags     <= fin_flags;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (cand_ready) begin
                        // rounding rolled over 1.11..1: renormalize with one right shift
                        mant_r <= {1'b1, {MW{1'b0}}};
                        state  <= NORM;
                    end else begin
                        state  <= NORM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Bench for fp_subtractor_seq: directed vectors, backpressure, mid-op reset and random ops
// checked against an exact-arithmetic model with truncation toward zero.
module tb_fp_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid;
    logic [31:0] result;
    logic [2:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_subtractor_seq #(.X(32), .EXP_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    // Operand scaled so the larger operand's LSB sits at bit 60; anything far below that is
    // replaced by 1 since only "nonzero and under one ulp" matters for truncation.
    function automatic logic [127:0] scaled(input logic [7:0] e, input logic [22:0] f, input logic [7:0] emax);
        int d;
        if (e == 8'd0) return '0;
        d = int'(emax) - int'(e);
        if (d >= 60) return 128'd1;
        return 128'({1'b1, f}) << (60 - d);
    endfunction

    // returns {flags, result}
    function automatic logic [34:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
        logic [7:0]   ex, ey, emax;
        logic         sx, sy, s;
        logic [127:0] vx, vy, mag, mshift;
        int           p, e;
        ex = x[30:23];
        ey = y[30:23];
        sx = x[31];
        sy = ~y[31];
        if (ex == 8'hFF || ey == 8'hFF) return {3'b100, 32'h7FC00000};
        emax = (ex > ey) ? ex : ey;
        vx = scaled(ex, x[22:0], emax);
        vy = scaled(ey, y[22:0], emax);
        if (sx == sy) begin mag = vx + vy; s = sx; end
        else if (vx >= vy) begin mag = vx - vy; s = sx; end
        else begin mag = vy - vx; s = sy; end
        if (mag == '0) return 35'd0;
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e = int'(emax) + p - 83;
        if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (e <= 0) return {3'b001, 32'd0};
        mshift = mag >> (p - 23);
        return {3'b000, s, 8'(e), mshift[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp(input int eref);
        int e;
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel == 0) e = 0;
        else if (sel == 1) e = 255;
        else if (sel == 2) e = int'($urandom_range(1, 254));
        else begin
            e = eref + int'($urandom_range(0, 8)) - 4;
            if (e < 0) e = 0;
            if (e > 254) e = 254;
        end
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    // Called at a negedge; returns at the negedge after the output handshake.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv,
                         output logic [31:0] r, output logic [2:0] fl, output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        if (!in_ready) check("accept_timeout", in_ready, 1);
        a = ta; b = tbv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
        r = result; fl = flags;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
    endtask

    logic [31:0] d_a   [9] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h4B800000, 32'h7F7FFFFF,
                               32'h00000000, 32'h3F800001, 32'h00800001, 32'hC0400000};
    logic [31:0] d_b   [9] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'hFF7FFFFF,
                               32'h3F800000, 32'h3F800000, 32'h00800000, 32'h40400000};
    logic [31:0] d_res [9] = '{32'h40000000, 32'hBF000000, 32'h00000000, 32'h4B7FFFFF, 32'h7F800000,
                               32'hBF800000, 32'h34000000, 32'h00000000, 32'hC0C00000};
    logic [2:0]  d_flg [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b001, 3'b000};
    int          d_lat [9] = '{3, 4, 3, 4, 4, 3, 26, 26, 4};

    initial begin
        logic [31:0] r;
        logic [2:0]  fl;
        logic [34:0] m;
        logic [31:0] ta, tbv;
        int          lat, eref;

        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_op(d_a[i], d_b[i], r, fl, lat);
            check("dir_result", r, d_res[i]);
            check("dir_flags", fl, d_flg[i]);
            check("dir_latency", 64'(lat), 64'(d_lat[i]));
        end

        // NaN result held under backpressure while new requests are offered
        a = 32'h7FC00000; b = $urandom; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
        if (!out_valid) check("nan_timeout", out_valid, 1);
        check("nan_result", result, 32'h7FC00000);
        check("nan_flags", flags, 3'b100);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(negedge clk);
            check("hold_result", result, 32'h7FC00000);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_release", out_valid, 0);
        check("hold_idle_ready", in_ready, 1);
        repeat (5) @(negedge clk);
        check("hold_no_capture", out_valid, 0);

        // reset while normalizing a long left-shift chain
        a = 32'h3F800001; b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_no_result", out_valid, 0);
        do_op(32'h40400000, 32'h3F800000, r, fl, lat);
        check("post_rst_result", r, 32'h40000000);
        check("post_rst_flags", fl, 3'b000);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: eref = 1;
                1: eref = 2;
                2: eref = 254;
                3: eref = 127;
                default: eref = int'($urandom_range(1, 254));
            endcase
            ta = rand_fp(eref);
            case ($urandom_range(0, 3))
                0: tbv = rand_fp(eref);
                1: tbv = {1'($urandom), ta[30:0]};
                2: tbv = {1'($urandom), ta[30:0] ^ (31'd1 << $urandom_range(0, 7))};
                default: tbv = {1'($urandom), ta[30:23], 23'($urandom)};
            endcase
            m = ref_sub(ta, tbv);
            do_op(ta, tbv, r, fl, lat);
            check("rand_result", r, m[31:0]);
            check("rand_flags", fl, m[34:32]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
